// File: rtl/alu_1_arbiter_pkg.sv
// Shared FSM encoding and action-word field positions for the alu_1 arbiter.
package alu_1_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int OPC_MSB = 24;
    localparam int OPC_LSB = 21;

endpackage

// File: rtl/alu_1_arbiter_if.sv
// Requester-side bus: per-slot op requests in, tagged ALU responses out.
interface alu_1_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48
);
    localparam int IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ACTION_LEN-1:0] req_action;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op1;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_op2;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic [IW-1:0]                 rsp_id;
    logic                          rsp_valid;

    modport master (
        output req_valid, req_action, req_op1, req_op2,
        input  req_ready, rsp_data, rsp_id, rsp_valid
    );

    modport slave (
        input  req_valid, req_action, req_op1, req_op2,
        output req_ready, rsp_data, rsp_id, rsp_valid
    );
endinterface

// File: rtl/alu_1_arbiter_rr.sv
// Combinational round-robin pick: first request at or after ptr, wrapping.
module alu_1_arbiter_rr #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);
    logic [IW:0] slot;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        slot  = '0;
        // walk from the farthest slot back so the nearest hit after ptr is written last
        for (int k = N - 1; k >= 0; k--) begin
            slot = {1'b0, ptr} + (IW+1)'(k);
            if (slot >= (IW+1)'(N))
                slot = slot - (IW+1)'(N);
            if (req[slot[IW-1:0]]) begin
                grant                 = '0;
                grant[slot[IW-1:0]]   = 1'b1;
                idx                   = slot[IW-1:0];
                any                   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_1_arbiter.sv
// Shares one alu_1 among NUM_REQ requesters: RR grant, single issue, wait with
// watchdog, and return the result tagged with the owning requester.
module alu_1_arbiter
    import alu_1_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ACTION_LEN = 25,
    parameter int DATA_WIDTH = 48,
    parameter int TIMEOUT    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_1_arbiter_if.slave        bus,
    output logic [ACTION_LEN-1:0] alu_action,
    output logic                  alu_action_valid,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_result_valid,
    output logic                  busy,
    output logic                  err_timeout,
    output logic                  err_unexpected
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int WW = $clog2(TIMEOUT);

    state_t                              state;
    logic [IW-1:0]                       ptr, owner, gnt_idx;
    logic [WW-1:0]                       wdog;
    logic [NUM_REQ-1:0]                  gnt;
    logic                                gnt_any;
    logic [NUM_REQ-1:0][ACTION_LEN-1:0]  act_v;
    logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  op1_v, op2_v;

    assign act_v = bus.req_action;
    assign op1_v = bus.req_op1;
    assign op2_v = bus.req_op2;

    alu_1_arbiter_rr #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req   (bus.req_valid),
        .ptr   (ptr),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    // grant is only offered while idle and out of reset; accept is unconditional
    assign bus.req_ready = (rst_n && state == ST_IDLE) ? gnt : '0;
    assign busy          = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            ptr              <= '0;
            owner            <= '0;
            wdog             <= '0;
            alu_action       <= '0;
            alu_op1          <= '0;
            alu_op2          <= '0;
            alu_action_valid <= 1'b0;
            bus.rsp_data     <= '0;
            bus.rsp_id       <= '0;
            bus.rsp_valid    <= 1'b0;
            err_timeout      <= 1'b0;
            err_unexpected   <= 1'b0;
        end else begin
            alu_action_valid <= 1'b0;
            bus.rsp_valid    <= 1'b0;
            err_timeout      <= 1'b0;
            err_unexpected   <= alu_result_valid && (state != ST_WAIT);
            case (state)
                ST_IDLE: if (gnt_any) begin
                    owner            <= gnt_idx;
                    alu_action       <= act_v[gnt_idx];
                    alu_op1          <= op1_v[gnt_idx];
                    alu_op2          <= op2_v[gnt_idx];
                    alu_action_valid <= 1'b1;
                    ptr              <= (gnt_idx == IW'(NUM_REQ - 1)) ? '0 : gnt_idx + IW'(1);
                    state            <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    wdog  <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    wdog <= wdog + WW'(1);
                    // a result arriving on the expiry cycle still wins
                    if (alu_result_valid) begin
                        bus.rsp_data  <= alu_result;
                        bus.rsp_id    <= owner;
                        bus.rsp_valid <= 1'b1;
                        state         <= ST_IDLE;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        err_timeout <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
